t_ff_bank: RTL
==============

Name: t_ff_bank

Overview:
- Parametrised successor to the single-bit toggle flip-flop: WIDTH toggle flip-flops sharing clock, reset, set and enable.
- Runs in one of three modes: per-bit toggle (q ^= t), synchronous up-counter, or synchronous down-counter.
- Counter modes use T-flip-flop carry equations.
- Used as a general toggle/event register and as a small counter in control paths.

Parameters:
- WIDTH, 4: number of flip-flops (1..32).
- RESET_VAL, 0: value loaded into q on reset; WIDTH bits, zero-extended or truncated.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  enables mode operation. Set, load and reset ignore en.
- set  in  1  synchronous set: all q bits go to 1.
- load  in  1  synchronous parallel load of load_val.
- load_val  in  WIDTH  value for load.
- mode  in  2  00 TOGGLE, 01 COUNT_UP, 10 COUNT_DOWN, 11 HOLD.
- t  in  WIDTH  per-bit toggle enables. Used only in TOGGLE mode.
- q  out  WIDTH  register state.
- qb  out  WIDTH  always equals ~q. Registered alongside q, never skewed.
- tc  out  1  registered terminal-count flag.

Behaviour:
- One clock: clk. Reset: reset, synchronous, active-high. No asynchronous paths.
- Priority per rising edge: reset > set > load > (en && mode op) > hold.
- Reset: q=RESET_VAL, qb=~RESET_VAL, tc=0. A reset in mid-count wins outright; the next cycle starts from RESET_VAL.
- Set: q=all-ones, qb=0, tc=0.
- Load: q=load_val, qb=~load_val, tc=0.
- TOGGLE (en=1): q[i] toggles where t[i]=1 and holds elsewhere. tc=0.
- COUNT_UP (en=1):
  - Bit i toggle enable is &q[i-1:0]; bit 0 always toggles.
  - The result equals q+1 mod 2^WIDTH.
  - Wrap all-ones→0 sets tc=1 for exactly the next cycle.
- COUNT_DOWN (en=1):
  - Bit i toggle enable is &(~q[i-1:0]).
  - The result equals q-1 mod 2^WIDTH.
  - Wrap 0→all-ones sets tc=1 for one cycle.
- HOLD or en=0: q and qb unchanged, tc=0.
- tc is a one-cycle pulse. Under continuous counting it is high for the single cycle after each wrap edge, so it coincides with q=0 (up) or q=all-ones (down).
- Mode may change on any cycle. The new mode applies at that edge; there is no pipeline.
- Latency: one clock from input to q/tc.
- WIDTH=1: counting degenerates to toggling every enabled cycle. tc pulses on every 1→0 (up) or 0→1 (down) edge.

Optional Feature:
- Macro: T_FF_BANK_SATURATE_EN.
- Defined:
  - COUNT_UP at all-ones and COUNT_DOWN at zero hold q instead of wrapping.
  - tc=1 on every cycle an enabled step is attempted at the limit, so it stays high while held there with en=1.
  - TOGGLE mode is unaffected.
- Undefined: wrap-around behaviour as above.

Decomposition:
- Package t_ff_bank_pkg:
  - mode_t enum: MODE_TOGGLE=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_HOLD=2'b11.
  - MAX_WIDTH=32 constant.
- Sub-module t_ff_cell: one bit with synchronous reset value, set, load, toggle enable; outputs q/qb.
- The bank instantiates WIDTH cells via generate and computes per-bit toggle enables and tc.

Test Plan (WIDTH=4, RESET_VAL=0):
- Reset: reset=1 with set=1 and load=1 → q=0000, qb=1111, tc=0. Release reset with mode=HOLD → q stays 0000.
- TOGGLE: t=0101, en=1, 2 cycles → q=0101 then 0000. en=0 with t=1111 → q unchanged.
- COUNT_UP: load 1110, then count up → q=1111, then 0000 with tc=1 that cycle only, then 0001 with tc=0.
  - With T_FF_BANK_SATURATE_EN: q stays 1111 and tc stays 1.
- COUNT_DOWN: from 0001 → q=0000, then 1111 with tc=1 for one cycle.
  - With T_FF_BANK_SATURATE_EN: q holds 0000 with tc=1.
- Priority: set=1 and load=1 (load_val=0011) → q=1111. Then load=1 with en=1, mode=UP → q=0011, not 0100.
- Reset mid-count: counting up at q=0110, assert reset one cycle → q=0000, tc=0. Counting resumes 0001.

Source files
------------

// File: rtl/t_ff_bank_pkg.sv
// Shared types and constants for the toggle flip-flop bank.
package t_ff_bank_pkg;

    // Operating modes selected by the mode input.
    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    // Widest bank supported; also the width of the RESET_VAL parameter.
    localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/t_ff_bank_cell.sv
// Single toggle flip-flop with synchronous reset value, set, load and toggle
// enable. q and qb are held in separate registers that always update together,
// so qb is never skewed from ~q.
module t_ff_cell #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic load,
    input  logic load_bit,
    input  logic toggle,
    output logic q,
    output logic qb
);

    logic q_reg;
    logic qb_reg;

    // Priority: reset > set > load > toggle > hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg  <= RESET_BIT;
            qb_reg <= ~RESET_BIT;
        end else if (set) begin
            q_reg  <= 1'b1;
            qb_reg <= 1'b0;
        end else if (load) begin
            q_reg  <= load_bit;
            qb_reg <= ~load_bit;
        end else if (toggle) begin
            q_reg  <= ~q_reg;
            qb_reg <= ~qb_reg;
        end
    end

    assign q  = q_reg;
    assign qb = qb_reg;

endmodule

// File: rtl/t_ff_bank.sv
// WIDTH toggle flip-flops sharing clock, reset, set and enable. Operates as a
// per-bit toggle register, an up-counter or a down-counter built from
// T-flip-flop carry chains, with a registered terminal-count pulse.
// Build option: define T_FF_BANK_SATURATE_EN to make the counters stop at
// all-ones (up) / zero (down) instead of wrapping.
module t_ff_bank
    import t_ff_bank_pkg::*;
#(
    parameter int                   WIDTH     = 4,
    parameter logic [MAX_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             set,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc
);

    localparam logic [WIDTH-1:0] RESET_BITS = RESET_VAL[WIDTH-1:0];

    mode_t            mode_sel;
    logic [WIDTH:0]   up_chain;    // up_chain[i] = &q[i-1:0]; top bit = q is all-ones
    logic [WIDTH:0]   dn_chain;    // dn_chain[i] = &~q[i-1:0]; top bit = q is zero
    logic [WIDTH-1:0] toggle_next;
    logic             tc_next;
    logic             tc_reg;

    assign mode_sel = mode_t'(mode);

    assign up_chain[0] = 1'b1;
    assign dn_chain[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            // Ripple carry / borrow terms for the T-flip-flop counter.
            assign up_chain[gi+1] = up_chain[gi] & q[gi];
            assign dn_chain[gi+1] = dn_chain[gi] & ~q[gi];

            t_ff_cell #(
                .RESET_BIT (RESET_BITS[gi])
            ) u_cell (
                .clk      (clk),
                .reset    (reset),
                .set      (set),
                .load     (load),
                .load_bit (load_val[gi]),
                .toggle   (toggle_next[gi]),
                .q        (q[gi]),
                .qb       (qb[gi])
            );
        end
    endgenerate

    // Per-bit toggle enables for the selected mode.
    always_comb begin
        toggle_next = '0;
        if (en) begin
            case (mode_sel)
                MODE_TOGGLE: toggle_next = t;
                MODE_UP: begin
                    toggle_next = up_chain[WIDTH-1:0];
`ifdef T_FF_BANK_SATURATE_EN
                    if (up_chain[WIDTH]) toggle_next = '0;
`endif
                end
                MODE_DOWN: begin
                    toggle_next = dn_chain[WIDTH-1:0];
`ifdef T_FF_BANK_SATURATE_EN
                    if (dn_chain[WIDTH]) toggle_next = '0;
`endif
                end
                default: toggle_next = '0;
            endcase
        end
    end

    // A counting step taken at the limit either wraps or (saturating) is
    // blocked; both raise the terminal-count flag for the following cycle.
    always_comb begin
        tc_next = 1'b0;
        if (en) begin
            case (mode_sel)
                MODE_UP:   tc_next = up_chain[WIDTH];
                MODE_DOWN: tc_next = dn_chain[WIDTH];
                default:   tc_next = 1'b0;
            endcase
        end
    end

    // Terminal-count register; reset, set and load all clear it.
    always_ff @(posedge clk) begin
        if (reset || set || load) begin
            tc_reg <= 1'b0;
        end else begin
            tc_reg <= tc_next;
        end
    end

    assign tc = tc_reg;

endmodule
